rr_grant_ctrl: RTL and testbench
================================

RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of requesters (legal >= 2).
REQ-002 SHALL have parameter MAX_HOLD, default 8, max cycles a grant is held before forced release (0 disables timeout).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  WIDTH  request vector, bit n = requester n.
REQ-006 SHALL have port i_done  input  1  grant holder finished; releases current grant.
REQ-007 SHALL have port o_gnt  output  WIDTH  registered one-hot grant vector.
REQ-008 SHALL have port o_gnt_idx  output  $clog2(WIDTH)  index of current grant holder.
REQ-009 SHALL have port o_gnt_valid  output  1  high while a grant is held.
REQ-010 SHALL have port o_timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL instantiate masked_priority_encoder with LSB=1, i_vec=i_req, i_idx=last-granted pointer, giving circular ascending search starting at pointer+1.
REQ-012 SHALL implement FSM with states IDLE (no grant) and GRANT (grant held).
REQ-013 IDLE: if encoder o_valid, SHALL register o_gnt=one-hot(encoder o_idx), o_gnt_idx=o_idx, o_gnt_valid=1, go to GRANT; grant visible 1 cycle after request (latency 1).
REQ-014 IDLE with i_req=0 SHALL remain IDLE, outputs zero.
REQ-015 GRANT: grant SHALL hold unchanged while i_done=0 and timeout not reached, regardless of i_req (dropping req does not release).
REQ-016 Release event = i_done=1 or hold counter reaching MAX_HOLD-1 in GRANT.
REQ-017 On release, pointer SHALL load current o_gnt_idx in the same edge.
REQ-018 On release, if any other requester (i_req with holder bit masked off) is set, SHALL grant the next one in circular order at the next edge, staying in GRANT (back-to-back, no dead cycle).
REQ-019 On release with no other requester, SHALL go to IDLE, clearing o_gnt, o_gnt_valid; holder re-requesting SHALL be granted from IDLE next cycle at earliest.
REQ-020 Hold counter width $clog2(MAX_HOLD+1); SHALL clear on every new grant and on IDLE, increment each GRANT cycle, saturate at release point.
REQ-021 Forced release SHALL assert o_timeout for exactly the cycle after the releasing edge; i_done and timeout simultaneous SHALL count as normal release, o_timeout=0.
REQ-022 MAX_HOLD=0 SHALL disable counter; release only on i_done; o_timeout tied 0.
REQ-023 i_done in IDLE SHALL be ignored.
REQ-024 o_gnt SHALL be one-hot or zero every cycle; o_gnt_valid == |o_gnt; o_gnt_idx=0 when not valid.
REQ-025 Pointer SHALL wrap: after holder WIDTH-1, search starts at index 0.

Reset
REQ-026 On i_rst_n=0, SHALL asynchronously clear o_gnt, o_gnt_idx, o_gnt_valid, o_timeout, hold counter, FSM to IDLE.
REQ-027 Reset SHALL set pointer to WIDTH-1 so first grant after reset goes to lowest requesting index.
REQ-028 Reset asserted mid-grant SHALL drop grant immediately (asynchronously); first grant after deassertion follows REQ-027.

Verification (WIDTH=4, MAX_HOLD=8)
REQ-029 Reset release, i_req=4'b1111 steady, i_done pulsed each grant -> grant order 0,1,2,3,0, back-to-back, o_gnt 4'b0001,0010,0100,1000,0001.
REQ-030 i_req=4'b0100 only, i_done after 3 cycles -> o_gnt=4'b0100 one cycle after req, held 3 cycles, then IDLE with outputs 0.
REQ-031 Holder 1 with i_req=4'b1011, never i_done -> release after 8 grant cycles, o_timeout pulse 1 cycle, next grant idx 3.
REQ-032 Holder 3, i_req=4'b1001, i_done -> next grant idx 0 (wrap-around).
REQ-033 Holder 2 drops i_req while i_done=0 -> grant stays 4'b0100 until i_done.
REQ-034 i_rst_n low during GRANT idx 2 -> o_gnt=0 immediately; after deassert with i_req=4'b1100 -> grant idx 2.

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: one holder at a time, released by i_done or an
// optional hold timeout, with back-to-back handoff to the next requester in circular order.

module masked_priority_encoder #(
  parameter int WIDTH = 4,
  parameter bit LSB   = 1'b1
) (
  input  logic [WIDTH-1:0]         i_vec,
  input  logic [$clog2(WIDTH)-1:0] i_idx,
  output logic                     o_valid,
  output logic [$clog2(WIDTH)-1:0] o_idx
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [IDX_W-1:0] pos;

  // Search starts one past i_idx and wraps, so i_idx itself has the lowest priority.
  // NOTE: every output gets a default before the loop so no path leaves a latch behind.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    pos     = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      if (LSB) pos = IDX_W'((int'(i_idx) + k) % WIDTH);
      else     pos = IDX_W'((int'(i_idx) + WIDTH - k) % WIDTH);
      if (!o_valid && i_vec[pos]) begin
        o_valid = 1'b1;
        o_idx   = pos;
      end
    end
  end

endmodule

module rr_grant_ctrl #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_req,
  input  logic                     i_done,
  output logic [WIDTH-1:0]         o_gnt,
  output logic [$clog2(WIDTH)-1:0] o_gnt_idx,
  output logic                     o_gnt_valid,
  output logic                     o_timeout
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [WIDTH-1:0] ONE_HOT0  = WIDTH'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] gnt_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             gnt_valid_q;
  logic             timeout_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;

  logic [WIDTH-1:0] enc_vec;
  logic [IDX_W-1:0] enc_ptr;
  logic             enc_valid;
  logic [IDX_W-1:0] enc_idx;
  logic             hold_expired;
  logic             release_evt;

  // While a grant is held, the encoder already looks past the current holder so a
  // release can hand off on the very same edge that the pointer takes the holder's index.
  assign enc_vec      = (state_q == GRANT) ? (i_req & ~gnt_q) : i_req;
  assign enc_ptr      = (state_q == GRANT) ? gnt_idx_q : ptr_q;
  assign hold_expired = (MAX_HOLD != 0) && (state_q == GRANT) && (hold_cnt_q == HOLD_LAST);
  assign release_evt  = (state_q == GRANT) && (i_done || hold_expired);

  masked_priority_encoder #(
    .WIDTH (WIDTH),
    .LSB   (1'b1)
  ) u_enc (
    .i_vec   (enc_vec),
    .i_idx   (enc_ptr),
    .o_valid (enc_valid),
    .o_idx   (enc_idx)
  );

  // NOTE: all state here is sequential, so only non-blocking assignments are used;
  // every register sees the old value of every other register on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= IDX_W'(WIDTH - 1);
      hold_cnt_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          hold_cnt_q <= '0;
          if (enc_valid) begin
            state_q     <= GRANT;
            gnt_q       <= ONE_HOT0 << enc_idx;
            gnt_idx_q   <= enc_idx;
            gnt_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (release_evt) begin
            ptr_q      <= gnt_idx_q;
            hold_cnt_q <= '0;
            // A simultaneous i_done makes this an ordinary release, not a timeout.
            timeout_q  <= hold_expired && !i_done;
            if (enc_valid) begin
              gnt_q     <= ONE_HOT0 << enc_idx;
              gnt_idx_q <= enc_idx;
            end else begin
              state_q     <= IDLE;
              gnt_q       <= '0;
              gnt_idx_q   <= '0;
              gnt_valid_q <= 1'b0;
            end
          end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_LAST)) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_idx   = gnt_idx_q;
  assign o_gnt_valid = gnt_valid_q;
  assign o_timeout   = (MAX_HOLD == 0) ? 1'b0 : timeout_q;

  a_gnt_onehot0 : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(gnt_q));
  a_valid_match : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    gnt_valid_q == (|gnt_q));
  a_idx_zero    : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    gnt_valid_q || (gnt_idx_q == '0));

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: a high-level arbitration model predicts each
// cycle's outputs, and an independent monitor compares them after every clock edge.

module tb_rr_grant_ctrl;

  localparam int W  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         i_rst_n;
  logic [W-1:0] i_req;
  logic         i_done;
  logic [W-1:0] o_gnt;
  logic [1:0]   o_gnt_idx;
  logic         o_gnt_valid;
  logic         o_timeout;

  rr_grant_ctrl #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_done      (i_done),
    .o_gnt       (o_gnt),
    .o_gnt_idx   (o_gnt_idx),
    .o_gnt_valid (o_gnt_valid),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] gnt;
    logic [1:0]   idx;
    logic         valid;
    logic         tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: who holds the grant (-1 = nobody), whose turn was last, cycles held so far.
  int m_holder;
  int m_ptr;
  int m_held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int next_after(input int ptr, input logic [W-1:0] vec);
    for (int k = 1; k <= W; k++) begin
      if (vec[(ptr + k) % W]) return (ptr + k) % W;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = W - 1;
    m_held   = 0;
  endtask

  // One clock of arbitration rules; pushes the outputs expected after the coming edge.
  task automatic model_cycle(input logic [W-1:0] req, input logic done);
    exp_t e;
    logic forced;
    logic [W-1:0] others;
    forced = 1'b0;
    if (m_holder < 0) begin
      m_holder = next_after(m_ptr, req);
      m_held   = (m_holder >= 0) ? 1 : 0;
    end else if (done || (MH > 0 && m_held == MH)) begin
      forced   = !done;
      m_ptr    = m_holder;
      others   = req & ~(W'(1) << m_holder);
      m_holder = next_after(m_ptr, others);
      m_held   = (m_holder >= 0) ? 1 : 0;
    end else begin
      m_held++;
    end
    e.valid = (m_holder >= 0);
    e.gnt   = e.valid ? (W'(1) << m_holder) : '0;
    e.idx   = e.valid ? 2'(m_holder) : 2'd0;
    e.tmo   = forced;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [W-1:0] req, input logic done);
    @(negedge clk);
    i_req  = req;
    i_done = done;
    model_cycle(req, done);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},   32'(o_gnt),       32'd0);
    check({tag, "_idx"},   32'(o_gnt_idx),   32'd0);
    check({tag, "_valid"}, 32'(o_gnt_valid), 32'd0);
    check({tag, "_tmo"},   32'(o_timeout),   32'd0);
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    i_req  = '0;
    i_done = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("held_rst");
    i_rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: outputs are sampled 1 ns after each rising edge, away from the edge itself.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (i_rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",     32'(o_gnt),       32'(e.gnt));
        check("gnt_idx", 32'(o_gnt_idx),   32'(e.idx));
        check("valid",   32'(o_gnt_valid), 32'(e.valid));
        check("timeout", 32'(o_timeout),   32'(e.tmo));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r;
    i_rst_n = 1'b0;
    i_req   = '0;
    i_done  = 1'b0;
    model_reset();
    #3;
    check_zero("por");
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;

    // Full request set with i_done every grant: 0,1,2,3,0 back-to-back.
    step(4'b1111, 1'b0);
    repeat (4) step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Single requester held three cycles, then idle.
    async_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // Holder 1 never finishes: forced release after MAX_HOLD cycles, handoff to 3.
    step(4'b0010, 1'b0);
    repeat (MH) step(4'b1011, 1'b0);
    step(4'b1001, 1'b0);

    // Holder 3 finishes with requester 0 waiting: wrap-around.
    step(4'b1001, 1'b1);

    // Holder 2 withdraws its request but keeps the grant until i_done.
    step(4'b0100, 1'b1);
    repeat (3) step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Reset in the middle of a grant to 2, then first grant follows the reset pointer.
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    async_reset();
    step(4'b1100, 1'b0);
    step(4'b1100, 1'b0);

    // i_done coinciding with the timeout is an ordinary release.
    step(4'b1100, 1'b1);
    repeat (MH - 1) step(4'b1100, 1'b0);
    step(4'b1100, 1'b1);
    step(4'b0000, 1'b0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset();
      end else begin
        r = W'($urandom_range(0, (1 << W) - 1));
        if ($urandom_range(0, 4) == 0) r = '0;
        step(r, ($urandom_range(0, 3) == 0));
      end
    end

    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
